uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_frame_if.sv | 13 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_frame.sv | 136 +++++++++++++
 tb/tb_uart_tx_frame.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default bit timing and parity helpers.
// Used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    START_B  = 3'b001,
    DATA_B   = 3'b011,
    PARITY_B = 3'b010,
    STOP_B   = 3'b110
  } state_e;

  // 50 MHz system clock, 9600 baud
  localparam int unsigned BAUD_DIV_DEFAULT = 5208;

  localparam int unsigned PAR_MODE_EVEN = 0;
  localparam int unsigned PAR_MODE_ODD  = 1;

  // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/serial-line bundle between the debouncer side and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 Start;
  logic [DATA_BITS-1:0] Data_In;
  logic                 Tx;
  logic                 Busy;
  logic                 Done;

  modport master (output Start, output Data_In, input Tx, input Busy, input Done);
  modport slave  (input Start, input Data_In, output Tx, output Busy, output Done);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period divider; restarted at frame start so bit edges align to the start bit.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  output logic bit_end
);
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CNT_W'(BAUD_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Tx/Busy/Done all come straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = PAR_MODE_EVEN,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  uart_tx_frame_if.slave   bus
);
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 clear;
  logic                 bit_end;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (clear),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // The state is already IDLE during the Done cycle; a Start there is still refused.
        if (bus.Start && !done_q) begin
          shift_d  = bus.Data_In;
          parity_d = frame_parity(8'(bus.Data_In), 1'(PARITY_ODD));
          idx_d    = '0;
          stop_d   = 1'b0;
          busy_d   = 1'b1;
          tx_d     = 1'b0;
          clear    = 1'b1;
          state_d  = START_B;
        end
      end
      START_B: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA_B;
        end
      end
      DATA_B: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY_B;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP_B;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY_B: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP_B;
        end
      end
      STOP_B: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            stop_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Tx   = tx_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three parameterisations, expected line bits queued per Start.
module tb_uart_tx_frame;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic       start_a [3];
  logic [7:0] din_a   [3];
  logic       tx_a    [3];
  logic       busy_a  [3];
  logic       done_a  [3];

  uart_tx_frame_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) bus2 ();

  assign bus0.Start = start_a[0];
  assign bus0.Data_In = din_a[0];
  assign tx_a[0] = bus0.Tx;
  assign busy_a[0] = bus0.Busy;
  assign done_a[0] = bus0.Done;
  assign bus1.Start = start_a[1];
  assign bus1.Data_In = din_a[1];
  assign tx_a[1] = bus1.Tx;
  assign busy_a[1] = bus1.Busy;
  assign done_a[1] = bus1.Done;
  assign bus2.Start = start_a[2];
  assign bus2.Data_In = din_a[2];
  assign tx_a[2] = bus2.Tx;
  assign busy_a[2] = bus2.Busy;
  assign done_a[2] = bus2.Done;

  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.Clock(Clock), .Reset(Reset), .bus(bus0));
  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut1 (.Clock(Clock), .Reset(Reset), .bus(bus1));
  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut2 (.Clock(Clock), .Reset(Reset), .bus(bus2));

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int par_en, input int odd, input int stops);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par_en != 0) exp_q.push_back((^d) ^ 1'(odd));
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  // Returns at the negedge of the first Tx=0 cycle.
  task automatic pulse_start(input int d, input logic [7:0] data, input int par_en,
                             input int odd, input int stops);
    @(negedge Clock);
    start_a[d] = 1'b1;
    din_a[d]   = data;
    push_frame(data, par_en, odd, stops);
    @(negedge Clock);
    start_a[d] = 1'b0;
    din_a[d]   = ~data;
  endtask

  // Every bit must hold for exactly 4 clocks with Busy high; then Busy falls with Done.
  task automatic run_frame(input int d, input int nb, input string tag, input bit poke);
    for (int b = 0; b < nb; b++) begin
      logic e;
      bit   ok;
      ok = 1'b1;
      e  = 1'b1;
      if (exp_q.size() == 0) chk({tag, " queue_underflow"}, 1'b0, 1'b1);
      else e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (tx_a[d] !== e || busy_a[d] !== 1'b1 || done_a[d] !== 1'b0) ok = 1'b0;
        @(negedge Clock);
      end
      chk($sformatf("%s bit%0d", tag, b), ok, 1'b1);
    end
    chk({tag, " busy_fall"}, busy_a[d], 1'b0);
    chk({tag, " done_pulse"}, done_a[d], 1'b1);
    chk({tag, " tx_idle_end"}, tx_a[d], 1'b1);
    if (poke) begin
      start_a[d] = 1'b1;
      din_a[d]   = 8'h55;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      din_a[i]   = 8'h00;
    end
    @(negedge Clock);
    @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset tx%0d", i), tx_a[i], 1'b1);
      chk($sformatf("reset busy%0d", i), busy_a[i], 1'b0);
      chk($sformatf("reset done%0d", i), done_a[i], 1'b0);
    end
    Reset = 1'b0;

    // A5, even parity
    pulse_start(0, 8'hA5, 1, 0, 1);
    run_frame(0, 11, "t1", 1'b0);
    @(negedge Clock);
    chk("t1 done_single", done_a[0], 1'b0);
    chk("t1 busy_idle", busy_a[0], 1'b0);

    // 07 with odd then even parity
    pulse_start(1, 8'h07, 1, 1, 1);
    run_frame(1, 11, "t2odd", 1'b0);
    pulse_start(0, 8'h07, 1, 0, 1);
    run_frame(0, 11, "t2even", 1'b0);

    // Start mid-frame is ignored
    pulse_start(0, 8'hA5, 1, 0, 1);
    fork
      run_frame(0, 11, "t3", 1'b0);
      begin
        repeat (9) @(negedge Clock);
        start_a[0] = 1'b1;
        din_a[0]   = 8'hFF;
        @(negedge Clock);
        start_a[0] = 1'b0;
      end
    join

    // Back-to-back; a Start raised in the Done cycle must not be taken
    pulse_start(0, 8'hA5, 1, 0, 1);
    run_frame(0, 11, "t4a", 1'b1);
    pulse_start(0, 8'h3C, 1, 0, 1);
    run_frame(0, 11, "t4b", 1'b0);

    // Reset mid-frame
    pulse_start(0, 8'hA5, 1, 0, 1);
    exp_q.delete();
    repeat (20) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("t5 rst_tx", tx_a[0], 1'b1);
    chk("t5 rst_busy", busy_a[0], 1'b0);
    chk("t5 rst_done", done_a[0], 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      @(negedge Clock);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0) ok = 1'b0;
    end
    chk("t5 stays_idle", ok, 1'b1);

    // Start already high when reset releases
    @(negedge Clock);
    Reset      = 1'b1;
    start_a[0] = 1'b1;
    din_a[0]   = 8'h3C;
    push_frame(8'h3C, 1, 0, 1);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    start_a[0] = 1'b0;
    run_frame(0, 11, "t5b", 1'b0);

    // No parity, two stop bits
    pulse_start(2, 8'h00, 0, 0, 2);
    run_frame(2, 11, "t6", 1'b0);

    chk("queue_empty", exp_q.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
